ercm_err_monitor: RTL and testbench

Streaming error-statistics monitor placed directly downstream of the ERCM8 approximate multiplier. It accepts operand/approximate-product triples over a valid/ready handshake and recomputes the exact product for each triple. Over a programmable window it accumulates the absolute error, the maximum error and the count of erroneous samples. At the end of each window it presents one report over a second valid/ready handshake, for on-chip characterisation of mask/accuracy settings.

---
 rtl/ercm_err_monitor_pkg.sv | 6 +
 rtl/ercm_err_monitor_if.sv | 24 ++
 rtl/ercm_abs_diff.sv | 15 +
 rtl/ercm_err_monitor.sv | 94 +++++++++
 tb/tb_ercm_err_monitor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ercm_err_monitor_pkg.sv
// ercm_pkg: shared state encoding and datapath widths for the ERCM error monitor
package ercm_pkg;
  localparam int PROD_W = 16;
  localparam int OPND_W = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;
endpackage

// File: rtl/ercm_err_monitor_if.sv
// ercm_err_monitor_if: sample-in and report-out handshakes of the error monitor
interface ercm_err_monitor_if import ercm_pkg::*; #(parameter int WIN_LOG2 = 8, parameter int SUM_W = 24);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic [PROD_W-1:0] in_prod;
  logic busy;
  logic rpt_valid;
  logic rpt_ready;
  logic [SUM_W-1:0] rpt_sum;
  logic [PROD_W-1:0] rpt_max;
  logic [WIN_LOG2:0] rpt_cnt;
  logic rpt_over;
  modport master (
    output start, in_valid, in_a, in_b, in_prod, rpt_ready,
    input in_ready, busy, rpt_valid, rpt_sum, rpt_max, rpt_cnt, rpt_over
  );
  modport slave (
    input start, in_valid, in_a, in_b, in_prod, rpt_ready,
    output in_ready, busy, rpt_valid, rpt_sum, rpt_max, rpt_cnt, rpt_over
  );
endinterface

// File: rtl/ercm_abs_diff.sv
// ercm_abs_diff: |exact - approx| of two unsigned products plus a nonzero flag
module ercm_abs_diff import ercm_pkg::*; (
  input  logic [PROD_W-1:0] i_exact,
  input  logic [PROD_W-1:0] i_approx,
  output logic [PROD_W-1:0] o_err,
  output logic              o_nz
);
  logic [PROD_W:0] w_diff;
  // Signed 17-bit difference; the magnitude of a negative value always fits 16 bits
  always_comb begin
    w_diff = {1'b0, i_exact} - {1'b0, i_approx};
    o_err  = w_diff[PROD_W] ? PROD_W'(-w_diff) : w_diff[PROD_W-1:0];
    o_nz   = |o_err;
  end
endmodule

// File: rtl/ercm_err_monitor.sv
// ercm_err_monitor: windowed error statistics of an approximate multiplier
module ercm_err_monitor import ercm_pkg::*; #(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 24
) (
  input logic clk,
  input logic rst_n,
  ercm_err_monitor_if.slave bus
);
  localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};
  state_t r_state, w_next;
  logic [WIN_LOG2:0] r_acc;
  logic r_s1_v;
  logic [PROD_W-1:0] r_s1_exact, r_s1_prod;
  logic [SUM_W-1:0] r_sum;
  logic [PROD_W-1:0] r_max;
  logic [WIN_LOG2:0] r_cnt;
  logic r_over;
  logic w_start, w_accept, w_last, w_in_ready, w_busy, w_rpt_valid, w_nz;
  logic [PROD_W-1:0] w_err;
  logic [SUM_W:0] w_sum_ext;

  assign w_start   = bus.start && r_state == IDLE;
  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_last    = w_accept && r_acc == WIN_LAST;
  assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(w_err);

  ercm_abs_diff u_abs (
    .i_exact (r_s1_exact),
    .i_approx(r_s1_prod),
    .o_err   (w_err),
    .o_nz    (w_nz)
  );

  // State register
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // Next state: DRAIN leaves once S1 is empty, since S2 retires in the same edge S1 drains into it
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (bus.start ? ACCUM : IDLE) :
             r_state == ACCUM ? (w_last ? DRAIN : ACCUM) :
             r_state == DRAIN ? (r_s1_v ? DRAIN : REPORT) :
                                (bus.rpt_ready ? IDLE : REPORT);
  end

  // State-decoded handshake outputs
  always_comb begin
    w_in_ready  = r_state == ACCUM && !r_acc[WIN_LOG2];
    w_busy      = r_state != IDLE;
    w_rpt_valid = r_state == REPORT;
  end

  // Sample counter and S1 pipeline stage capturing the exact and approximate products
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_acc      <= '0;
      r_s1_v     <= 1'b0;
      r_s1_exact <= '0;
      r_s1_prod  <= '0;
    end else begin
      r_s1_v <= w_accept;
      if (w_start) r_acc <= '0;
      else if (w_accept) r_acc <= r_acc + 1'b1;
      if (w_accept) begin
        r_s1_exact <= PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
        r_s1_prod  <= bus.in_prod;
      end
    end

  // S2 stage: saturating sum, running max, nonzero-error count, sticky overflow
  always_ff @(posedge clk)
    if (!rst_n || w_start) begin
      r_sum  <= '0;
      r_max  <= '0;
      r_cnt  <= '0;
      r_over <= 1'b0;
    end else if (r_s1_v) begin
      r_sum  <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
      r_over <= r_over | w_sum_ext[SUM_W];
      r_max  <= w_err > r_max ? w_err : r_max;
      r_cnt  <= r_cnt + (WIN_LOG2+1)'(w_nz);
    end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.rpt_valid = w_rpt_valid;
  assign bus.rpt_sum   = r_sum;
  assign bus.rpt_max   = r_max;
  assign bus.rpt_cnt   = r_cnt;
  assign bus.rpt_over  = r_over;
endmodule

// File: tb/tb_ercm_err_monitor.sv
// tb_ercm_err_monitor: scoreboard bench for the ERCM error-statistics monitor
module tb_ercm_err_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ercm_err_monitor_if #(.WIN_LOG2(2), .SUM_W(24)) ia ();
  ercm_err_monitor_if #(.WIN_LOG2(1), .SUM_W(16)) ib ();

  ercm_err_monitor #(.WIN_LOG2(2), .SUM_W(24)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  ercm_err_monitor #(.WIN_LOG2(1), .SUM_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  typedef struct {int sum; int mx; int cnt; bit over;} rpt_t;
  rpt_t sb[$];
  int errors = 0;
  int checks = 0;
  int va[4], vb[4], vp[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int n, input int lim);
    rpt_t e;
    e = '{0, 0, 0, 1'b0};
    for (int i = 0; i < n; i++) begin
      int d;
      d = va[i] * vb[i] - vp[i];
      if (d < 0) d = -d;
      e.sum += d;
      if (e.sum > lim) begin
        e.sum = lim;
        e.over = 1'b1;
      end
      if (d > e.mx) e.mx = d;
      if (d != 0) e.cnt++;
    end
    sb.push_back(e);
  endtask

  task automatic start_a();
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    checks++;
    if (ia.busy !== 1'b1 || ia.rpt_cnt !== 3'd0 || ia.rpt_over !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: busy=%b cnt=%0d over=%b want busy=1 cnt=0 over=0", ia.busy, ia.rpt_cnt, ia.rpt_over);
    end
  endtask

  task automatic send_a(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ia.in_a = va[i][7:0];
      ia.in_b = vb[i][7:0];
      ia.in_prod = vp[i][15:0];
      ia.in_valid = 1'b1;
      for (int k = 0; k < 20 && ia.in_ready !== 1'b1; k++) tick();
      checks++;
      if (ia.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_wait: got %b want 1 for sample %0d", ia.in_ready, i);
      end
      tick();
      ia.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_rpt_a(input string tag);
    rpt_t e;
    for (int k = 0; k < 20 && ia.rpt_valid !== 1'b1; k++) tick();
    checks++;
    if (ia.rpt_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_valid: rpt_valid=%b queued=%0d want 1 and a queued report", tag, ia.rpt_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (ia.rpt_sum !== 24'(e.sum)) begin errors++; $display("FAIL %s_sum: got %0d want %0d", tag, ia.rpt_sum, e.sum); end
    checks++;
    if (ia.rpt_max !== 16'(e.mx)) begin errors++; $display("FAIL %s_max: got %0d want %0d", tag, ia.rpt_max, e.mx); end
    checks++;
    if (ia.rpt_cnt !== 3'(e.cnt)) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", tag, ia.rpt_cnt, e.cnt); end
    checks++;
    if (ia.rpt_over !== e.over) begin errors++; $display("FAIL %s_over: got %b want %b", tag, ia.rpt_over, e.over); end
  endtask

  task automatic ack_a(input string tag);
    ia.rpt_ready = 1'b1;
    tick();
    ia.rpt_ready = 1'b0;
    checks++;
    if (ia.rpt_valid !== 1'b0 || ia.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: rpt_valid=%b busy=%b want 0 0", tag, ia.rpt_valid, ia.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (ia.in_ready !== 1'b0 || ia.busy !== 1'b0 || ia.rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b rpt_valid=%b want 0 0 0", ia.in_ready, ia.busy, ia.rpt_valid);
    end
    checks++;
    if (ia.rpt_sum !== 24'd0 || ia.rpt_max !== 16'd0 || ia.rpt_cnt !== 3'd0 || ia.rpt_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_rpt: sum=%0d max=%0d cnt=%0d over=%b want all 0", ia.rpt_sum, ia.rpt_max, ia.rpt_cnt, ia.rpt_over);
    end
    checks++;
    if (ib.in_ready !== 1'b0 || ib.busy !== 1'b0 || ib.rpt_valid !== 1'b0 || ib.rpt_sum !== 16'd0 || ib.rpt_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: in_ready=%b busy=%b valid=%b sum=%0d over=%b want all 0", ib.in_ready, ib.busy, ib.rpt_valid, ib.rpt_sum, ib.rpt_over);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact();
    start_a();
    va = '{3, 3, 3, 3};
    vb = '{5, 5, 5, 5};
    vp = '{15, 15, 15, 15};
    push_model(4, 32'hFFFFFF);
    send_a(4, 0);
    checks++;
    if (ia.rpt_valid !== 1'b0 || ia.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exact_e0: rpt_valid=%b in_ready=%b want 0 0", ia.rpt_valid, ia.in_ready);
    end
    tick();
    checks++;
    if (ia.rpt_valid !== 1'b0) begin errors++; $display("FAIL exact_e1: rpt_valid=%b want 0", ia.rpt_valid); end
    tick();
    checks++;
    if (ia.rpt_valid !== 1'b1) begin errors++; $display("FAIL exact_e2: rpt_valid=%b want 1", ia.rpt_valid); end
    check_rpt_a("exact");
    ack_a("exact");
  endtask

  task automatic test_mixed();
    start_a();
    va = '{10, 10, 20, 255};
    vb = '{10, 10, 20, 255};
    vp = '{100, 96, 410, 65000};
    push_model(4, 32'hFFFFFF);
    send_a(4, 2);
    check_rpt_a("mixed");
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      ia.start = (c == 3);
      tick();
      checks++;
      if (ia.rpt_valid !== 1'b1 || ia.in_ready !== 1'b0 || ia.busy !== 1'b1 ||
          ia.rpt_sum !== 24'd39 || ia.rpt_max !== 16'd25 || ia.rpt_cnt !== 3'd3 || ia.rpt_over !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b rdy=%b busy=%b sum=%0d max=%0d cnt=%0d over=%b want 1 0 1 39 25 3 0",
                 c, ia.rpt_valid, ia.in_ready, ia.busy, ia.rpt_sum, ia.rpt_max, ia.rpt_cnt, ia.rpt_over);
      end
    end
    ia.start = 1'b1;
    ia.rpt_ready = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.rpt_ready = 1'b0;
    checks++;
    if (ia.rpt_valid !== 1'b0 || ia.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack: rpt_valid=%b busy=%b want 0 0", ia.rpt_valid, ia.busy);
    end
    tick();
    checks++;
    if (ia.busy !== 1'b0 || ia.rpt_sum !== 24'd39 || ia.rpt_cnt !== 3'd3) begin
      errors++;
      $display("FAIL bp_idle_keep: busy=%b sum=%0d cnt=%0d want 0 39 3", ia.busy, ia.rpt_sum, ia.rpt_cnt);
    end
  endtask

  task automatic test_saturation();
    rpt_t e;
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    va[0] = 255; vb[0] = 255; vp[0] = 0;
    va[1] = 255; vb[1] = 255; vp[1] = 0;
    push_model(2, 65535);
    for (int i = 0; i < 2; i++) begin
      ib.in_a = va[i][7:0];
      ib.in_b = vb[i][7:0];
      ib.in_prod = vp[i][15:0];
      ib.in_valid = 1'b1;
      for (int k = 0; k < 20 && ib.in_ready !== 1'b1; k++) tick();
      checks++;
      if (ib.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready: got %b want 1", ib.in_ready); end
      tick();
      ib.in_valid = 1'b0;
    end
    for (int k = 0; k < 20 && ib.rpt_valid !== 1'b1; k++) tick();
    checks++;
    if (ib.rpt_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_valid: got %b want 1", ib.rpt_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (ib.rpt_sum !== 16'(e.sum) || ib.rpt_max !== 16'(e.mx) || ib.rpt_cnt !== 2'(e.cnt) || ib.rpt_over !== e.over) begin
        errors++;
        $display("FAIL sat_rpt: sum=%0d max=%0d cnt=%0d over=%b want %0d %0d %0d %b",
                 ib.rpt_sum, ib.rpt_max, ib.rpt_cnt, ib.rpt_over, e.sum, e.mx, e.cnt, e.over);
      end
    end
    ib.rpt_ready = 1'b1;
    tick();
    ib.rpt_ready = 1'b0;
    checks++;
    if (ib.rpt_valid !== 1'b0 || ib.busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_ack: rpt_valid=%b busy=%b want 0 0", ib.rpt_valid, ib.busy);
    end
  endtask

  task automatic test_reset_mid();
    start_a();
    va = '{10, 20, 0, 0};
    vb = '{10, 20, 0, 0};
    vp = '{96, 410, 0, 0};
    send_a(2, 0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (ia.busy !== 1'b0 || ia.in_ready !== 1'b0 || ia.rpt_valid !== 1'b0 ||
        ia.rpt_sum !== 24'd0 || ia.rpt_max !== 16'd0 || ia.rpt_cnt !== 3'd0 || ia.rpt_over !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rdy=%b valid=%b sum=%0d max=%0d cnt=%0d over=%b want all 0",
               ia.busy, ia.in_ready, ia.rpt_valid, ia.rpt_sum, ia.rpt_max, ia.rpt_cnt, ia.rpt_over);
    end
    rst_n = 1'b1;
    tick();
    start_a();
    va = '{7, 12, 200, 1};
    vb = '{9, 12, 100, 255};
    vp = '{63, 144, 20000, 255};
    push_model(4, 32'hFFFFFF);
    send_a(4, 1);
    check_rpt_a("mid_new");
    ack_a("mid_new");
  endtask

  initial begin
    ia.start = 1'b0; ia.in_valid = 1'b0; ia.in_a = '0; ia.in_b = '0; ia.in_prod = '0; ia.rpt_ready = 1'b0;
    ib.start = 1'b0; ib.in_valid = 1'b0; ib.in_a = '0; ib.in_b = '0; ib.in_prod = '0; ib.rpt_ready = 1'b0;
    test_reset();
    test_exact();
    test_mixed();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
